qsfp_mgmt_ctrl: RTL

// Wishbone-mapped QSFP+ low-speed control/status block on sys_clk, beside the QSFP+ I2C master.

---
 rtl/qsfp_mgmt_ctrl.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/qsfp_mgmt_ctrl.sv
// QSFP+ low-speed sideband control/status block with Wishbone register access.
// Debounces module presence, sequences reset/init, and latches events for an interrupt.
module qsfp_mgmt_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES    = 1000000,
  parameter int unsigned RESET_PULSE_CYCLES = 1000,
  parameter int unsigned INIT_WAIT_CYCLES   = 200000000,
  parameter int unsigned CNT_WIDTH          = 28
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        modprs_b_i,
  input  logic        int_b_i,
  output logic        modsel_b_o,
  output logic        reset_b_o,
  output logic        lp_mode_o,
  output logic        module_ready_o,
  output logic        irq_o,
  input  logic [7:0]  wb_adr,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_we,
  input  logic        wb_stb,
  input  logic        wb_cyc,
  output logic        wb_ack
);

  typedef enum logic [1:0] {
    StAbsent   = 2'd0,
    StReset    = 2'd1,
    StInitWait = 2'd2,
    StReady    = 2'd3
  } state_e;

  localparam logic [CNT_WIDTH-1:0] DebLast  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] RstLast  = CNT_WIDTH'(RESET_PULSE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] InitLast = CNT_WIDTH'(INIT_WAIT_CYCLES - 1);

  localparam logic [7:0] AdrCtrl   = 8'h00;
  localparam logic [7:0] AdrStatus = 8'h01;
  localparam logic [7:0] AdrEvent  = 8'h02;
  localparam logic [7:0] AdrIrqEn  = 8'h03;
  localparam logic [7:0] AdrInsCnt = 8'h04;

  logic                 modprs_meta_q, modprs_sync_q;
  logic                 int_meta_q, int_sync_q, int_prev_q;
  logic                 present_q;
  logic [CNT_WIDTH-1:0] deb_cnt_q;
  state_e               state_q;
  logic [CNT_WIDTH-1:0] timer_q;
  logic [15:0]          insert_cnt_q;
  logic [2:0]           event_q, event_d, event_set, event_clr;
  logic [2:0]           irq_en_q;
  logic [31:0]          rdata;

  logic wb_req, wr_ctrl, wr_event, wr_irq_en, sw_reset_req;
  logic set_insert, set_remove, int_fall;
  logic unused_wdata;

  assign unused_wdata = ^wb_dat_i[31:3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      modprs_meta_q <= 1'b0;
      modprs_sync_q <= 1'b0;
      int_meta_q    <= 1'b0;
      int_sync_q    <= 1'b0;
      int_prev_q    <= 1'b0;
    end else begin
      modprs_meta_q <= modprs_b_i;
      modprs_sync_q <= modprs_meta_q;
      int_meta_q    <= int_b_i;
      int_sync_q    <= int_meta_q;
      int_prev_q    <= int_sync_q;
    end
  end

  // present is the inverse of modprs_b, so equality means the pin disagrees with present
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      present_q <= 1'b0;
      deb_cnt_q <= '0;
    end else if (modprs_sync_q == present_q) begin
      if (deb_cnt_q == DebLast) begin
        present_q <= ~present_q;
        deb_cnt_q <= '0;
      end else begin
        deb_cnt_q <= deb_cnt_q + 1'b1;
      end
    end else begin
      deb_cnt_q <= '0;
    end
  end

  assign wb_req       = wb_cyc & wb_stb & ~wb_ack;
  assign wr_ctrl      = wb_req & wb_we & (wb_adr == AdrCtrl);
  assign wr_event     = wb_req & wb_we & (wb_adr == AdrEvent);
  assign wr_irq_en    = wb_req & wb_we & (wb_adr == AdrIrqEn);
  assign sw_reset_req = wr_ctrl & wb_dat_i[0];

  assign set_insert = (state_q == StAbsent) & present_q;
  assign set_remove = (state_q != StAbsent) & ~present_q;
  assign int_fall   = int_prev_q & ~int_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StAbsent;
      timer_q        <= '0;
      reset_b_o      <= 1'b0;
      module_ready_o <= 1'b0;
    end else begin
      unique case (state_q)
        StAbsent: begin
          if (present_q) begin
            state_q <= StReset;
            timer_q <= '0;
          end
        end
        StReset: begin
          if (!present_q) begin
            state_q <= StAbsent;
            timer_q <= '0;
          end else if (timer_q == RstLast) begin
            state_q   <= StInitWait;
            timer_q   <= '0;
            reset_b_o <= 1'b1;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        StInitWait: begin
          if (!present_q) begin
            state_q   <= StAbsent;
            timer_q   <= '0;
            reset_b_o <= 1'b0;
          end else if (sw_reset_req) begin
            state_q   <= StReset;
            timer_q   <= '0;
            reset_b_o <= 1'b0;
          end else if (timer_q == InitLast) begin
            state_q        <= StReady;
            timer_q        <= '0;
            module_ready_o <= 1'b1;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        StReady: begin
          if (!present_q || sw_reset_req) begin
            state_q        <= present_q ? StReset : StAbsent;
            timer_q        <= '0;
            reset_b_o      <= 1'b0;
            module_ready_o <= 1'b0;
          end
        end
        default: begin
          state_q        <= StAbsent;
          timer_q        <= '0;
          reset_b_o      <= 1'b0;
          module_ready_o <= 1'b0;
        end
      endcase
    end
  end

  // A same-cycle set beats the W1C clear
  always_comb begin
    event_set = {int_fall & present_q, set_remove, set_insert};
    event_clr = wr_event ? wb_dat_i[2:0] : 3'b000;
    event_d   = (event_q & ~event_clr) | event_set;
  end

  always_comb begin
    rdata = '0;
    case (wb_adr)
      AdrCtrl:   rdata[2:1]  = {modsel_b_o, lp_mode_o};
      AdrStatus: rdata[4:0]  = {state_q == StReady, state_q, ~int_sync_q, present_q};
      AdrEvent:  rdata[2:0]  = event_q;
      AdrIrqEn:  rdata[2:0]  = irq_en_q;
      AdrInsCnt: rdata[15:0] = insert_cnt_q;
      default:   rdata       = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ack       <= 1'b0;
      wb_dat_o     <= '0;
      lp_mode_o    <= 1'b0;
      modsel_b_o   <= 1'b0;
      irq_en_q     <= 3'b000;
      event_q      <= 3'b000;
      irq_o        <= 1'b0;
      insert_cnt_q <= '0;
    end else begin
      wb_ack   <= wb_req;
      wb_dat_o <= (wb_req && !wb_we) ? rdata : '0;
      if (wr_ctrl) begin
        lp_mode_o  <= wb_dat_i[1];
        modsel_b_o <= wb_dat_i[2];
      end
      if (wr_irq_en) irq_en_q <= wb_dat_i[2:0];
      event_q <= event_d;
      irq_o   <= |(event_q & irq_en_q);
      if (set_insert) insert_cnt_q <= insert_cnt_q + 16'd1;
    end
  end

endmodule
